// File: rtl/data_memory_ws.sv
// Load/store data memory with programmable wait states, sub-word access with
// sign/zero extension, and misalignment / out-of-range fault capture.
module data_memory_ws #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [1:0]  Size,
  input  logic        SignExt,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        Fault,
  output logic        FaultSticky,
  output logic [31:0] FaultAddr
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    CNT_W'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);
  localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);

  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             fault_sticky_q, fault_sticky_d;
  logic [31:0]      fault_addr_q, fault_addr_d;

  logic [31:0]      mem_q [DEPTH_WORDS];

  logic             req_c;
  logic             complete_c;
  logic             we_c;
  logic             bad_c;
  logic [IDX_W-1:0] idx_c;
  logic [3:0]       be_c;
  logic [31:0]      wr_lanes_c;
  logic [31:0]      rd_word_c;
  logic [7:0]       rd_byte_c;
  logic [15:0]      rd_half_c;
  logic [31:0]      rd_ext_c;

  assign req_c = MemRead | MemWrite;
  assign idx_c = Address[IDX_W+1:2];

  // State register and wait counter.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: a request either completes now or counts down its wait states.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_c && (WAIT_STATES != 0)) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_WAIT: begin
        if (!req_c || (cnt_q == '0)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Access decode: fault detection, store lane placement, load lane extraction.
  always_comb begin
    bad_c      = 1'b0;
    be_c       = 4'b1111;
    wr_lanes_c = WriteData;
    rd_word_c  = mem_q[idx_c];
    rd_byte_c  = rd_word_c[{Address[1:0], 3'b000} +: 8];
    rd_half_c  = rd_word_c[{Address[1], 4'b0000} +: 16];
    rd_ext_c   = rd_word_c;

    if (Address[31:2] >= DEPTH_LIM) begin
      bad_c = 1'b1;
    end

    case (Size)
      SZ_HALF: begin
        if (Address[0]) begin
          bad_c = 1'b1;
        end
        be_c       = Address[1] ? 4'b1100 : 4'b0011;
        wr_lanes_c = {2{WriteData[15:0]}};
        rd_ext_c   = SignExt ? {{16{rd_half_c[15]}}, rd_half_c}
                             : {16'h0000, rd_half_c};
      end
      SZ_BYTE: begin
        be_c       = 4'b0001 << Address[1:0];
        wr_lanes_c = {4{WriteData[7:0]}};
        rd_ext_c   = SignExt ? {{24{rd_byte_c[7]}}, rd_byte_c}
                             : {24'h000000, rd_byte_c};
      end
      default: begin
        if (Address[1:0] != 2'b00) begin
          bad_c = 1'b1;
        end
      end
    endcase
  end

  // Outputs: completion detection, stall, fault pulse, write enable, load data.
  always_comb begin
    complete_c = 1'b0;
    Stall      = 1'b0;
    Fault      = 1'b0;
    we_c       = 1'b0;
    ReadData   = '0;

    if (!Reset && req_c) begin
      if (state_q == ST_IDLE) begin
        complete_c = (WAIT_STATES == 0);
      end else begin
        complete_c = (cnt_q == '0);
      end
      Stall = !complete_c;
    end

    Fault = complete_c & bad_c;
    we_c  = complete_c & MemWrite & ~bad_c;

    if (complete_c && MemRead && !MemWrite && !bad_c) begin
      ReadData = rd_ext_c;
    end
  end

  // Byte-lane write port; the array itself is never reset.
  always_ff @(posedge Clk) begin
    if (we_c) begin
      for (int b = 0; b < 4; b++) begin
        if (be_c[b]) begin
          mem_q[idx_c][8*b +: 8] <= wr_lanes_c[8*b +: 8];
        end
      end
    end
  end

  // First fault wins: later faults leave the captured address alone.
  always_comb begin
    fault_sticky_d = fault_sticky_q;
    fault_addr_d   = fault_addr_q;
    if (Fault && !fault_sticky_q) begin
      fault_sticky_d = 1'b1;
      fault_addr_d   = Address;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      fault_sticky_q <= 1'b0;
      fault_addr_q   <= '0;
    end else begin
      fault_sticky_q <= fault_sticky_d;
      fault_addr_q   <= fault_addr_d;
    end
  end

  assign FaultSticky = fault_sticky_q;
  assign FaultAddr   = fault_addr_q;

endmodule

// File: tb/tb_data_memory_ws.sv
// Directed bench for data_memory_ws at 2, 0 and 3 wait states.
module tb_data_memory_ws;

  logic        clk;
  logic        rst_all, rst_sel;
  logic [1:0]  sel;
  logic [31:0] addr, wdata;
  logic        mem_write, mem_read;
  logic [1:0]  size;
  logic        sext;

  logic [2:0]  rst_v, mw_v, mr_v, stall_v, fault_v, sticky_v;
  logic [31:0] rdata_v [3];
  logic [31:0] faddr_v [3];

  logic        o_stall, o_fault, o_sticky;
  logic [31:0] o_rdata, o_faddr;

  int errors = 0;
  int checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Only the selected instance sees requests and the per-instance reset.
  assign rst_v = {rst_all | (rst_sel & (sel == 2'd2)),
                  rst_all | (rst_sel & (sel == 2'd1)),
                  rst_all | (rst_sel & (sel == 2'd0))};
  assign mw_v  = {mem_write & (sel == 2'd2), mem_write & (sel == 2'd1), mem_write & (sel == 2'd0)};
  assign mr_v  = {mem_read & (sel == 2'd2), mem_read & (sel == 2'd1), mem_read & (sel == 2'd0)};

  data_memory_ws #(.DEPTH_WORDS(1024), .WAIT_STATES(2), .CNT_W(8)) u_ws2 (
    .Clk(clk), .Reset(rst_v[0]), .Address(addr), .WriteData(wdata),
    .MemWrite(mw_v[0]), .MemRead(mr_v[0]), .Size(size), .SignExt(sext),
    .ReadData(rdata_v[0]), .Stall(stall_v[0]), .Fault(fault_v[0]),
    .FaultSticky(sticky_v[0]), .FaultAddr(faddr_v[0]));

  data_memory_ws #(.DEPTH_WORDS(1024), .WAIT_STATES(0), .CNT_W(8)) u_ws0 (
    .Clk(clk), .Reset(rst_v[1]), .Address(addr), .WriteData(wdata),
    .MemWrite(mw_v[1]), .MemRead(mr_v[1]), .Size(size), .SignExt(sext),
    .ReadData(rdata_v[1]), .Stall(stall_v[1]), .Fault(fault_v[1]),
    .FaultSticky(sticky_v[1]), .FaultAddr(faddr_v[1]));

  data_memory_ws #(.DEPTH_WORDS(1024), .WAIT_STATES(3), .CNT_W(8)) u_ws3 (
    .Clk(clk), .Reset(rst_v[2]), .Address(addr), .WriteData(wdata),
    .MemWrite(mw_v[2]), .MemRead(mr_v[2]), .Size(size), .SignExt(sext),
    .ReadData(rdata_v[2]), .Stall(stall_v[2]), .Fault(fault_v[2]),
    .FaultSticky(sticky_v[2]), .FaultAddr(faddr_v[2]));

  always_comb begin
    case (sel)
      2'd1: begin
        o_stall = stall_v[1]; o_fault = fault_v[1]; o_sticky = sticky_v[1];
        o_rdata = rdata_v[1]; o_faddr = faddr_v[1];
      end
      2'd2: begin
        o_stall = stall_v[2]; o_fault = fault_v[2]; o_sticky = sticky_v[2];
        o_rdata = rdata_v[2]; o_faddr = faddr_v[2];
      end
      default: begin
        o_stall = stall_v[0]; o_fault = fault_v[0]; o_sticky = sticky_v[0];
        o_rdata = rdata_v[0]; o_faddr = faddr_v[0];
      end
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Drive one access at a falling edge, check each stall cycle, then the completion cycle.
  task automatic access(input string tag, input logic wr, input logic rd,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [1:0] sz, input logic se, input int ws,
                        input logic [31:0] exp_rd, input logic exp_f);
    @(negedge clk);
    mem_write = wr; mem_read = rd; addr = a; wdata = wd; size = sz; sext = se;
    for (int i = 0; i < ws; i++) begin
      #1;
      chk({tag, "_stall"}, 32'(o_stall), 32'd1);
      chk({tag, "_stall_rd"}, o_rdata, 32'd0);
      @(negedge clk);
    end
    #1;
    chk({tag, "_done_stall"}, 32'(o_stall), 32'd0);
    chk({tag, "_rdata"}, o_rdata, exp_rd);
    chk({tag, "_fault"}, 32'(o_fault), 32'(exp_f));
  endtask

  task automatic idle(input string tag);
    @(negedge clk);
    mem_write = 1'b0; mem_read = 1'b0;
    #1;
    chk({tag, "_stall"}, 32'(o_stall), 32'd0);
    chk({tag, "_fault"}, 32'(o_fault), 32'd0);
  endtask

  initial begin
    sel = 2'd0; rst_all = 1'b1; rst_sel = 1'b0;
    mem_write = 1'b0; mem_read = 1'b1; addr = 32'h10; wdata = '0; size = 2'b00; sext = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      sel = 2'(k);
      #1;
      chk("rst_stall", 32'(o_stall), 32'd0);
      chk("rst_rdata", o_rdata, 32'd0);
      chk("rst_fault", 32'(o_fault), 32'd0);
      chk("rst_sticky", 32'(o_sticky), 32'd0);
      chk("rst_faddr", o_faddr, 32'd0);
    end
    @(negedge clk);
    rst_all = 1'b0; mem_read = 1'b0; sel = 2'd0;

    // Two wait states: word, byte and halfword traffic.
    access("t1_stw", 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 2'b00, 1'b0, 2, 32'h0, 1'b0);
    access("t1_ldw", 1'b0, 1'b1, 32'h10, 32'h0, 2'b00, 1'b0, 2, 32'hDEADBEEF, 1'b0);
    access("t2_stb", 1'b1, 1'b0, 32'h13, 32'h00000080, 2'b10, 1'b0, 2, 32'h0, 1'b0);
    access("t2_ldb_s", 1'b0, 1'b1, 32'h13, 32'h0, 2'b10, 1'b1, 2, 32'hFFFFFF80, 1'b0);
    access("t2_ldb_z", 1'b0, 1'b1, 32'h13, 32'h0, 2'b10, 1'b0, 2, 32'h00000080, 1'b0);
    access("t2_ldw", 1'b0, 1'b1, 32'h10, 32'h0, 2'b00, 1'b0, 2, 32'h80ADBEEF, 1'b0);
    access("t2_sth", 1'b1, 1'b0, 32'h12, 32'hFFFF7FFE, 2'b01, 1'b0, 2, 32'h0, 1'b0);
    access("t2_ldw2", 1'b0, 1'b1, 32'h10, 32'h0, 2'b00, 1'b0, 2, 32'h7FFEBEEF, 1'b0);
    access("t2_ldh_s", 1'b0, 1'b1, 32'h10, 32'h0, 2'b01, 1'b1, 2, 32'hFFFFBEEF, 1'b0);
    access("t2_ldh_z", 1'b0, 1'b1, 32'h10, 32'h0, 2'b01, 1'b0, 2, 32'h0000BEEF, 1'b0);
    access("t2_ldh_hi", 1'b0, 1'b1, 32'h12, 32'h0, 2'b01, 1'b1, 2, 32'h00007FFE, 1'b0);
    access("t2_sz3", 1'b0, 1'b1, 32'h10, 32'h0, 2'b11, 1'b1, 2, 32'h7FFEBEEF, 1'b0);
    access("t2_rw", 1'b1, 1'b1, 32'h18, 32'hCAFEF00D, 2'b00, 1'b0, 2, 32'h0, 1'b0);
    access("t2_ldrw", 1'b0, 1'b1, 32'h18, 32'h0, 2'b00, 1'b0, 2, 32'hCAFEF00D, 1'b0);

    // Faults: first address captured, later ones ignored.
    access("t4_misw", 1'b0, 1'b1, 32'h22, 32'h0, 2'b00, 1'b0, 2, 32'h0, 1'b1);
    chk("t4_sticky_pre", 32'(o_sticky), 32'd0);
    idle("t4_idle1");
    chk("t4_sticky1", 32'(o_sticky), 32'd1);
    chk("t4_faddr1", o_faddr, 32'h22);
    access("t4_mish", 1'b0, 1'b1, 32'h41, 32'h0, 2'b01, 1'b0, 2, 32'h0, 1'b1);
    idle("t4_idle2");
    chk("t4_faddr2", o_faddr, 32'h22);
    access("t4_oor", 1'b0, 1'b1, 32'h1000, 32'h0, 2'b00, 1'b0, 2, 32'h0, 1'b1);
    idle("t4_idle3");
    chk("t4_faddr3", o_faddr, 32'h22);
    chk("t4_sticky3", 32'(o_sticky), 32'd1);
    access("t4_misst", 1'b1, 1'b0, 32'h11, 32'h11111111, 2'b00, 1'b0, 2, 32'h0, 1'b1);
    access("t4_ldchk", 1'b0, 1'b1, 32'h10, 32'h0, 2'b00, 1'b0, 2, 32'h7FFEBEEF, 1'b0);

    // Abort mid-wait, then a fresh load pays the full wait.
    @(negedge clk);
    mem_write = 1'b1; mem_read = 1'b0; addr = 32'h10; wdata = 32'h0BADF00D; size = 2'b00;
    #1;
    chk("t6_stall0", 32'(o_stall), 32'd1);
    @(negedge clk);
    mem_write = 1'b0;
    #1;
    chk("t6_abort_stall", 32'(o_stall), 32'd0);
    chk("t6_abort_fault", 32'(o_fault), 32'd0);
    access("t6_ld", 1'b0, 1'b1, 32'h10, 32'h0, 2'b00, 1'b0, 2, 32'h7FFEBEEF, 1'b0);

    // Zero wait states.
    idle("t3_pre");
    sel = 2'd1;
    access("t3_stw", 1'b1, 1'b0, 32'h20, 32'h12345678, 2'b00, 1'b0, 0, 32'h0, 1'b0);
    access("t3_ldw", 1'b0, 1'b1, 32'h20, 32'h0, 2'b00, 1'b0, 0, 32'h12345678, 1'b0);
    access("t3_stb", 1'b1, 1'b0, 32'h22, 32'h000000AB, 2'b10, 1'b0, 0, 32'h0, 1'b0);
    access("t3_ldb", 1'b0, 1'b1, 32'h22, 32'h0, 2'b10, 1'b0, 0, 32'h000000AB, 1'b0);
    access("t3_ldw2", 1'b0, 1'b1, 32'h20, 32'h0, 2'b00, 1'b0, 0, 32'h12AB5678, 1'b0);
    access("t3_fh", 1'b0, 1'b1, 32'h21, 32'h0, 2'b01, 1'b0, 0, 32'h0, 1'b1);
    idle("t3_idle");
    chk("t3_sticky", 32'(o_sticky), 32'd1);
    chk("t3_faddr", o_faddr, 32'h21);

    // Three wait states with reset during the wait.
    idle("t5_pre");
    sel = 2'd2;
    access("t5_st", 1'b1, 1'b0, 32'h30, 32'h55AA55AA, 2'b00, 1'b0, 3, 32'h0, 1'b0);
    @(negedge clk);
    mem_write = 1'b1; mem_read = 1'b0; addr = 32'h30; wdata = 32'hFFFFFFFF; size = 2'b00;
    #1;
    chk("t5_stall0", 32'(o_stall), 32'd1);
    @(negedge clk);
    rst_sel = 1'b1;
    #1;
    chk("t5_rst_stall", 32'(o_stall), 32'd0);
    @(negedge clk);
    rst_sel = 1'b0; mem_write = 1'b0;
    #1;
    chk("t5_post_stall", 32'(o_stall), 32'd0);
    access("t5_ld", 1'b0, 1'b1, 32'h30, 32'h0, 2'b00, 1'b0, 3, 32'h55AA55AA, 1'b0);
    idle("t5_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
